// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, scan-level debounce, key encode with one-cycle strobes.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTO_REPEAT_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] keypad_code,
    output logic       keypad_valid,
    output logic       key_held,
    output logic       key_release
);

    localparam int unsigned   DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB       = 4'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("DEBOUNCE_SCANS must be in 1..15");
    end
    if (REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_repeat
        $error("REPEAT_SCANS must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_PEND,
        S_HELD,
        S_RELEASE_PEND
    } state_t;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    col_q;
    logic [15:0]   image_q, image_d;
    logic          scan_done_q;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       release_q, release_d;
    logic       held_q, held_d;
`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam logic [7:0] REP = 8'(REPEAT_SCANS);
    logic [7:0] rep_q, rep_d;
`endif

    logic       none_c, single_c;
    logic [3:0] key_c;

    // Image bit row*4+col is set when that key was sensed during the last scan.
    always_comb begin
        image_d = image_q;
        for (int r = 0; r < 4; r++) begin
            image_d[{2'(r), col_idx_q}] = row_s2_q[r];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1_q    <= 4'b0000;
            row_s2_q    <= 4'b0000;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b0001;
            image_q     <= 16'h0000;
            scan_done_q <= 1'b0;
        end else begin
            row_s1_q <= key_row;
            row_s2_q <= row_s1_q;
            if (dwell_q == DWELL_MAX) begin
                dwell_q     <= '0;
                col_idx_q   <= col_idx_q + 2'd1;
                col_q       <= {col_q[2:0], col_q[3]};
                image_q     <= image_d;
                scan_done_q <= (col_idx_q == 2'd3);
            end else begin
                dwell_q     <= dwell_q + DW'(1);
                scan_done_q <= 1'b0;
            end
        end
    end

    // Scan classification: NONE, SINGLE(key_c) or MULTI (neither flag set).
    always_comb begin
        key_c = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (image_q[i]) begin
                key_c = 4'(i);
            end
        end
        none_c   = (image_q == 16'h0000);
        single_c = ($countones(image_q) == 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            cand_q    <= 4'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rep_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            release_q <= release_d;
            held_q    <= held_d;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    // Debouncer advances only on scan-result cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
        rep_d     = rep_q;
`endif
        if (scan_done_q) begin
            case (state_q)
                S_IDLE: begin
                    if (single_c) begin
                        if (DEB == 4'd1) begin
                            state_d = S_HELD;
                            code_d  = key_c;
                            valid_d = 1'b1;
                            cnt_d   = 4'd0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                            rep_d   = 8'd0;
`endif
                        end else begin
                            state_d = S_PRESS_PEND;
                            cand_d  = key_c;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                S_PRESS_PEND: begin
                    if (single_c && key_c == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB) begin
                            state_d = S_HELD;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            cnt_d   = 4'd0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                            rep_d   = 8'd0;
`endif
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                S_HELD: begin
                    if (none_c) begin
                        if (DEB == 4'd1) begin
                            state_d   = S_IDLE;
                            release_d = 1'b1;
                            cnt_d     = 4'd0;
                        end else begin
                            state_d = S_RELEASE_PEND;
                            cnt_d   = 4'd1;
                        end
                    end
`ifdef KEYPAD_AUTO_REPEAT_EN
                    else if (single_c && key_c == code_q) begin
                        rep_d = rep_q + 8'd1;
                        if (rep_d == REP) begin
                            valid_d = 1'b1;
                            rep_d   = 8'd0;
                        end
                    end else begin
                        rep_d = 8'd0;
                    end
`endif
                end
                S_RELEASE_PEND: begin
                    if (none_c) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB) begin
                            state_d   = S_IDLE;
                            release_d = 1'b1;
                            cnt_d     = 4'd0;
                        end
                    end else begin
                        state_d = S_HELD;
                        cnt_d   = 4'd0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                        rep_d   = 8'd0;
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        held_d = (state_d == S_HELD) || (state_d == S_RELEASE_PEND);
    end

    assign key_col      = col_q;
    assign keypad_code  = code_q;
    assign keypad_valid = valid_q;
    assign key_held     = held_q;
    assign key_release  = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a key-matrix model drives the rows, a per-scan reference
// model predicts each scan-result outcome; build with KEYPAD_AUTO_REPEAT_EN to cover repeats.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned REP      = 3;
    localparam int          SCAN_LEN = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] keypad_code;
    logic       keypad_valid;
    logic       key_held;
    logic       key_release;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_SCANS(REP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_row(key_row),
        .key_col(key_col),
        .keypad_code(keypad_code),
        .keypad_valid(keypad_valid),
        .key_held(key_held),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key connects its driven column to its row.
    logic [15:0] keys;
    always_comb begin
        key_row = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && key_col[c]) key_row[r] = 1'b1;
    end

    int cyc;
    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         valid;
        bit         rel;
        logic [3:0] code;
        bit         held;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: 0 idle, 1 press pending, 2 held, 3 release pending.
    int m_state, m_cand, m_cnt, m_code, m_rep;

    task automatic model_reset();
        m_state = 0; m_cand = 0; m_cnt = 0; m_code = 0; m_rep = 0;
    endtask

    task automatic scan(input logic [15:0] s);
        exp_t e;
        int   n;
        int   k;
        bit   v, rl;
        n = $countones(s);
        k = 0;
        for (int i = 0; i < 16; i++) if (s[i]) k = i;
        v = 0; rl = 0;
        case (m_state)
            0: if (n == 1) begin
                m_cand = k; m_cnt = 1; m_state = 1;
                if (m_cnt == DEB) begin m_state = 2; m_code = k; v = 1; m_rep = 0; end
            end
            1: if (n == 1 && k == m_cand) begin
                m_cnt++;
                if (m_cnt == DEB) begin m_state = 2; m_code = m_cand; v = 1; m_rep = 0; end
            end else begin
                m_state = 0;
            end
            2: if (n == 0) begin
                m_cnt = 1; m_state = 3;
                if (m_cnt == DEB) begin m_state = 0; rl = 1; end
            end else begin
`ifdef KEYPAD_AUTO_REPEAT_EN
                if (n == 1 && k == m_code) begin
                    m_rep++;
                    if (m_rep == REP) begin v = 1; m_rep = 0; end
                end else begin
                    m_rep = 0;
                end
`endif
            end
            default: if (n == 0) begin
                m_cnt++;
                if (m_cnt == DEB) begin m_state = 0; rl = 1; end
            end else begin
                m_state = 2; m_rep = 0;
            end
        endcase
        keys    = s;
        e.cyc   = cyc + SCAN_LEN + 1;
        e.valid = v;
        e.rel   = rl;
        e.code  = 4'(m_code);
        e.held  = (m_state >= 2);
        sb.push_back(e);
        repeat (SCAN_LEN) @(negedge clk);
    endtask

    task automatic scans(input logic [15:0] s, input int cnt);
        for (int i = 0; i < cnt; i++) scan(s);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key_col"}, int'(key_col), 1);
        chk({tag, "_code"}, int'(keypad_code), 0);
        chk({tag, "_valid"}, int'(keypad_valid), 0);
        chk({tag, "_held"}, int'(key_held), 0);
        chk({tag, "_release"}, int'(key_release), 0);
    endtask

    task automatic do_reset(input string tag);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs({tag, "_async"});
        repeat (3) @(negedge clk);
        check_reset_outputs({tag, "_hold"});
        model_reset();
        reset = 1'b0;
    endtask

    exp_t me;
    // Monitor: consumes one prediction per scan-result and forbids strobes at any other time.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                me = sb.pop_front();
                chk("keypad_valid", int'(keypad_valid), int'(me.valid));
                chk("key_release", int'(key_release), int'(me.rel));
                chk("key_held", int'(key_held), int'(me.held));
                chk("keypad_code", int'(keypad_code), int'(me.code));
            end else begin
                chk("idle_strobe", int'(keypad_valid | key_release), 0);
            end
        end
    end

    logic [15:0] prev, s, one;
    int          r;

    initial begin
        one   = 16'h0001;
        keys  = 16'h0000;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // Clean press of row0/col1.
        scans(16'h0002, 4);
        scans(16'h0000, 3);
        // Bounce on row1/col2.
        scan(16'h0040);
        scan(16'h0000);
        scans(16'h0040, 3);
        scans(16'h0000, 3);
        // Two keys on col0, then row1 released.
        scans(16'h0011, 3);
        scans(16'h0001, 3);
        scans(16'h0000, 3);
        // Release of code 3 with a one-scan reappearance.
        scans(16'h0008, 3);
        scan(16'h0000);
        scans(16'h0008, 2);
        scans(16'h0000, 3);
        // Reset while code 5 is held; the key stays down across reset.
        scans(16'h0020, 4);
        do_reset("mid_hold");
        scans(16'h0020, 4);
        scans(16'h0000, 3);
        // Long hold of code 2 (repeats only with the auto-repeat build).
        scans(16'h0004, 11);
        scans(16'h0000, 3);

        // Random key activity, biased towards keys staying put long enough to debounce.
        prev = 16'h0000;
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      s = prev;
            else if (r < 75) s = 16'h0000;
            else if (r < 92) s = one << $urandom_range(0, 15);
            else             s = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            scan(s);
            prev = s;
        end
        scans(16'h0000, 3);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
